multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multicycle control FSM that sequences the 16-bit Baej datapath: fetch, decode, execute, memory, write-back and I/O. It sits beside `datapath` and drives every mux select, write enable and ALU op from the 4-bit opcode and the ALU zero flag. It also gates the `ioIn`/`ioOut` path with a valid/ready handshake. A memory-ready handshake plus timeout makes stalls explicit.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles spent waiting on `mem_ready` before a bus error (range 1–255).
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 4: `IR[15:12]`, valid from DECODE onward.
- `zero` in 1: ALU result == 0, valid in EXEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `io_in_valid` in 1: `ioIn` holds fresh data.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `io_out_write` out 1 each: write/access strobes.
- `iord` out 1: memory address source; 0 = PC, 1 = ALU out.
- `pc_src` out 2: 0 = PC+2, 1 = branch target, 2 = jump immediate, 3 = register.
- `wb_src` out 2: 0 = ALU, 1 = MDR, 2 = PC (link), 3 = `ioIn`.
- `alu_src_b` out 2: 0 = reg B, 1 = const 2, 2 = sign-extended immediate, 3 = shifted immediate.
- `alu_op` out 3: 0 ADD, 1 SUB, 2 AND, 3 OR.
- `io_in_ready` out 1: control accepts `ioIn` this cycle.
- `halted` out 1: FSM is in HALT.
- `bus_error` out 1: sticky; set on memory timeout.
- `state` out 3: current state, for debug.

## Operation
- **Opcodes:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR: R-type.
  - 4 ADDI.
  - 5 LW, 6 SW.
  - 7 BEQ, 8 BNE.
  - 9 JAL, A JR.
  - B IN, C OUT.
  - F HALT.
  - D, E: illegal; executed as NOP.
- **States:** FETCH, DECODE, EXEC, MEM, WB, IO_WAIT, HALT.
- **FETCH:**
  - Asserts `mem_read=1`, `iord=0`, `alu_src_b=1`, `alu_op=ADD`.
  - On `mem_ready`: pulses `ir_write` and `pc_write` (`pc_src=0`), then goes to DECODE.
- **DECODE:**
  - Computes branch target (`alu_src_b=3`).
  - F → HALT; illegal → FETCH; B → IO_WAIT; otherwise → EXEC.
- **EXEC:**
  - R-type / ADDI: compute → WB.
  - LW/SW: address calculation (`alu_src_b=2`) → MEM.
  - BEQ/BNE: SUB; `pc_write=1`, `pc_src=1` when `zero` (BEQ) or `!zero` (BNE) → FETCH.
  - JAL: `reg_write=1`, `wb_src=2`, `pc_write=1`, `pc_src=2` → FETCH.
  - JR: `pc_write=1`, `pc_src=3` → FETCH.
  - OUT: `io_out_write=1` → FETCH.
- **MEM:**
  - Asserts `iord=1`, plus `mem_read` (LW) or `mem_write` (SW).
  - On `mem_ready`: LW → WB, SW → FETCH.
- **WB:** `reg_write=1`; `wb_src` = 1 for LW, else 0 → FETCH.
- **IO_WAIT:** `io_in_ready=1`. When `io_in_valid`: `reg_write=1`, `wb_src=3` → FETCH.
- **HALT:** absorbing; only reset exits.
- **Memory timeout:**
  - A wait counter clears on entry to FETCH or MEM and increments each cycle `mem_ready=0`.
  - When the count reaches `MEM_TIMEOUT` with `mem_ready` still 0: set `bus_error`, go to HALT, assert no strobes that cycle.
- **Default outputs:** any output not named for a state is 0.

## Timing
- All outputs are Moore/Mealy combinational from state, `opcode`, `zero` and handshake inputs; state is registered.
- **Reset:** state = FETCH, wait counter = 0, `bus_error` = 0, `halted` = 0; all strobes are 0 while `reset` is low.
- **Latency with `mem_ready` tied 1:**
  - R-type / ADDI: 4 cycles.
  - LW: 5; SW: 4.
  - BEQ, BNE, JAL, JR, OUT: 3.
  - IN: 3 + wait for `io_in_valid`.
  - Illegal: 2.
- **Memory stall:** each cycle without `mem_ready` adds one cycle; the strobe is held steady throughout.
- **`io_in_valid` already high on IO_WAIT entry:** completes in that same cycle.
- **Reset mid-operation:** immediate return to FETCH; no partial write completes.

## Configuration
- **`CU_PERF_COUNTERS_EN` defined:**
  - Adds outputs `cycle_count` [31:0] and `instr_retired` [31:0].
  - `cycle_count` increments every non-HALT cycle.
  - `instr_retired` increments on every transition into FETCH from a non-FETCH state.
  - Both wrap at 2^32 and reset to 0.
- **Not defined:** ports and logic are absent.

## Structure
- **Package `baej_ctrl_pkg`:**
  - opcode constants;
  - state enum (3-bit);
  - `pc_src` / `wb_src` / `alu_src_b` / `alu_op` encodings.
- **Sub-module `mem_wait_timer`:** wait counter and timeout compare, parameterised by `MEM_TIMEOUT`.

## Test plan
- ADD, `mem_ready`=1 → `ir_write` in cycle 1, `reg_write` with `wb_src=0` in cycle 4, back in FETCH in cycle 5.
- LW with `mem_ready` low 3 cycles in MEM → `mem_read`/`iord=1` held for 4 cycles, then WB with `wb_src=1`; total 8 cycles.
- BEQ, `zero=1` → `pc_write`, `pc_src=1` in EXEC. BNE, `zero=1` → no `pc_write` in EXEC.
- IN with `io_in_valid` raised 5 cycles after IO_WAIT entry → `io_in_ready` high 6 cycles, single `reg_write`, `wb_src=3`.
- `mem_ready` stuck 0 in FETCH, `MEM_TIMEOUT=15` → `bus_error` and HALT after 15 cycles; `reset` low returns to FETCH with `bus_error`=0.
- HALT opcode → `halted`=1 permanently; with `CU_PERF_COUNTERS_EN`, `cycle_count` freezes and `instr_retired` equals the number of instructions before HALT.

Source files
------------

// File: rtl/baej_ctrl_pkg.sv
// Shared encodings for the Baej multicycle control unit: opcodes, FSM states
// and the datapath select / ALU operation codes.
package baej_ctrl_pkg;

  // Opcodes (IR[15:12]); 4'hD and 4'hE are illegal and retire as NOPs
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_IN   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_IO_WAIT = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  // Next-PC source
  localparam logic [1:0] PC_SRC_PC2    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  // Register write-back source
  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MDR  = 2'd1;
  localparam logic [1:0] WB_SRC_PC   = 2'd2;
  localparam logic [1:0] WB_SRC_IOIN = 2'd3;

  // ALU operand B source
  localparam logic [1:0] ALUB_REG    = 2'd0;
  localparam logic [1:0] ALUB_CONST2 = 2'd1;
  localparam logic [1:0] ALUB_SEXT   = 2'd2;
  localparam logic [1:0] ALUB_SHIFT  = 2'd3;

  // ALU operations; R-type opcodes map directly onto these
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  function automatic logic is_rtype(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory access waits on mem_ready and flags a
// timeout on the MEM_TIMEOUT-th stalled cycle (MEM_TIMEOUT in 1..255).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,   // FSM is in a state that waits on memory
  input  logic i_ready,    // memory completes the access this cycle
  output logic o_timeout
);

  localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_count;

  // Count stalled cycles; any completion or leaving the waiting state clears
  // the count, so every new FETCH/MEM starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_active || i_ready) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_timeout = i_active && !i_ready && (r_count == LP_LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 16-bit Baej datapath.
// Optional build macro CU_PERF_COUNTERS_EN adds cycle_count / instr_retired.
module multicycle_control_unit
  import baej_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        io_in_valid,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        io_out_write,
  output logic        iord,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_src,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        io_in_ready,
  output logic        halted,
  output logic        bus_error,
  output logic [2:0]  state
`ifdef CU_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
`endif
);

  state_e r_state;
  state_e w_next;
  logic   w_timeout;
  logic   w_mem_wait;
  logic   r_bus_error;

  assign w_mem_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_active  (w_mem_wait),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  // Next state and all control outputs; everything is forced low while reset
  // is asserted so no partial write can slip out of an aborted instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    w_next       = r_state;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    io_out_write = 1'b0;
    iord         = 1'b0;
    pc_src       = PC_SRC_PC2;
    wb_src       = WB_SRC_ALU;
    alu_src_b    = ALUB_REG;
    alu_op       = ALU_ADD;
    io_in_ready  = 1'b0;

    if (reset) begin
      case (r_state)
        ST_FETCH: begin
          if (w_timeout) begin
            w_next = ST_HALT;
          end else begin
            mem_read  = 1'b1;
            alu_src_b = ALUB_CONST2;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              w_next   = ST_DECODE;
            end
          end
        end

        ST_DECODE: begin
          alu_src_b = ALUB_SHIFT;
          case (opcode)
            OP_HALT:    w_next = ST_HALT;
            4'hD, 4'hE: w_next = ST_FETCH;
            OP_IN:      w_next = ST_IO_WAIT;
            default:    w_next = ST_EXEC;
          endcase
        end

        ST_EXEC: begin
          w_next = ST_FETCH;
          if (is_rtype(opcode)) begin
            alu_op = {1'b0, opcode[1:0]};
            w_next = ST_WB;
          end else begin
            case (opcode)
              OP_ADDI: begin
                alu_src_b = ALUB_SEXT;
                w_next    = ST_WB;
              end
              OP_LW, OP_SW: begin
                alu_src_b = ALUB_SEXT;
                w_next    = ST_MEM;
              end
              OP_BEQ, OP_BNE: begin
                alu_op = ALU_SUB;
                if ((opcode == OP_BEQ) ? zero : !zero) begin
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_BRANCH;
                end
              end
              OP_JAL: begin
                reg_write = 1'b1;
                wb_src    = WB_SRC_PC;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_JUMP;
              end
              OP_JR: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_REG;
              end
              OP_OUT:  io_out_write = 1'b1;
              default: ;
            endcase
          end
        end

        ST_MEM: begin
          if (w_timeout) begin
            w_next = ST_HALT;
          end else begin
            iord      = 1'b1;
            mem_read  = (opcode == OP_LW);
            mem_write = (opcode == OP_SW);
            if (mem_ready) begin
              w_next = (opcode == OP_LW) ? ST_WB : ST_FETCH;
            end
          end
        end

        ST_WB: begin
          reg_write = 1'b1;
          wb_src    = (opcode == OP_LW) ? WB_SRC_MDR : WB_SRC_ALU;
          w_next    = ST_FETCH;
        end

        ST_IO_WAIT: begin
          io_in_ready = 1'b1;
          if (io_in_valid) begin
            reg_write = 1'b1;
            wb_src    = WB_SRC_IOIN;
            w_next    = ST_FETCH;
          end
        end

        ST_HALT: w_next = ST_HALT;

        default: w_next = ST_FETCH;
      endcase
    end
  end

  // State register and sticky bus error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_FETCH;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout) begin
        r_bus_error <= 1'b1;
      end
    end
  end

  assign state     = r_state;
  assign halted    = (r_state == ST_HALT);
  assign bus_error = r_bus_error;

`ifdef CU_PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_retired;

  // Free-running counters: active cycles, and completed instructions counted
  // on every return to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count   <= '0;
      r_instr_retired <= '0;
    end else begin
      if (r_state != ST_HALT) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if ((w_next == ST_FETCH) && (r_state != ST_FETCH)) begin
        r_instr_retired <= r_instr_retired + 32'd1;
      end
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instr_retired = r_instr_retired;
`endif

endmodule
